mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative integer multiply/divide unit (RV64M/RV32M style ops)
//
// Multiplies use radix-2 shift-add on operand magnitudes and divides use a
// restoring divider on magnitudes. Each takes N iterations (N = 32 for W ops,
// XLEN otherwise). One FIX cycle then applies sign correction and selects the
// high or low half. An operation takes N+2 edges from accept to out_valid.
//
// Parameters:
//   XLEN       datapath width, 32 or 64 (W ops are illegal when XLEN = 32)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid;  in_ready  high in IDLE
//   op         operation code (0 MUL .. 12 REMUW; 13-15 illegal)
//   src1/src2  operands
//   flush      kill any in-flight operation and block accept on that edge
//   out_valid  result valid (DONE);  out_ready  consumer takes result
//   result     operation result, held stable while in DONE
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, divide-by-zero and signed-overflow cases
//                     skip the iterations and go IDLE->DONE on the accept edge.

module mul_div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNTW = $clog2(XLEN);
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7,
    OP_MULW   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } opT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } stateT;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic dLegal, dIsW, dIsMul, dSignA, dSignB, dIsRem, dSelHi;

  always_comb begin
    dLegal = 1'b0;
    dIsW   = op[3];
    dIsMul = 1'b0;
    dSignA = 1'b0;
    dSignB = 1'b0;
    dIsRem = 1'b0;
    dSelHi = 1'b0;
    case (op)
      OP_MUL:    begin dLegal = 1'b1; dIsMul = 1'b1; end
      OP_MULH:   begin dLegal = 1'b1; dIsMul = 1'b1; dSignA = 1'b1; dSignB = 1'b1; dSelHi = 1'b1; end
      OP_MULHSU: begin dLegal = 1'b1; dIsMul = 1'b1; dSignA = 1'b1; dSelHi = 1'b1; end
      OP_MULHU:  begin dLegal = 1'b1; dIsMul = 1'b1; dSelHi = 1'b1; end
      OP_DIV:    begin dLegal = 1'b1; dSignA = 1'b1; dSignB = 1'b1; end
      OP_DIVU:   begin dLegal = 1'b1; end
      OP_REM:    begin dLegal = 1'b1; dSignA = 1'b1; dSignB = 1'b1; dIsRem = 1'b1; end
      OP_REMU:   begin dLegal = 1'b1; dIsRem = 1'b1; end
      OP_MULW:   begin dLegal = (XLEN == 64); dIsMul = 1'b1; end
      OP_DIVW:   begin dLegal = (XLEN == 64); dSignA = 1'b1; dSignB = 1'b1; end
      OP_DIVUW:  begin dLegal = (XLEN == 64); end
      OP_REMW:   begin dLegal = (XLEN == 64); dSignA = 1'b1; dSignB = 1'b1; dIsRem = 1'b1; end
      OP_REMUW:  begin dLegal = (XLEN == 64); dIsRem = 1'b1; end
      default:   dLegal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand preparation: values in operation width, magnitudes, special cases
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] valA, valB, magA, magB, minVal, remOnZero, specResC;
  logic            negA, negB, divZero, divOvf, special;

  always_comb begin
    if (dIsW) begin
      valA      = dSignA ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
      valB      = dSignB ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
      negA      = dSignA & src1[31];
      negB      = dSignB & src2[31];
      minVal    = sext32(32'h8000_0000);
      remOnZero = sext32(src1[31:0]);
    end else begin
      valA      = src1;
      valB      = src2;
      negA      = dSignA & src1[XLEN-1];
      negB      = dSignB & src2[XLEN-1];
      minVal    = {1'b1, {(XLEN-1){1'b0}}};
      remOnZero = src1;
    end
    // Negating a sign-extended W operand leaves a zero upper half.
    magA    = negA ? -valA : valA;
    magB    = negB ? -valB : valB;
    divZero = (valB == '0);
    divOvf  = dSignA & (valA == minVal) & (valB == '1);
    special = dLegal & ~dIsMul & (divZero | divOvf);
    if (divZero) begin
      specResC = dIsRem ? remOnZero : '1;
    end else begin
      specResC = dIsRem ? '0 : minVal;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  stateT           state;
  logic [CNTW-1:0] cnt;
  logic            rIsW, rIsMul, rIsRem, rSelHi, rNeg, rNegRem, rSpecial;
  logic [XLEN-1:0] rSpecRes;
  logic [PW-1:0]   acc, mcand;
  logic [XLEN-1:0] mplier, remR, quo, divisor;

  logic            lastIter;
  logic [XLEN:0]   remSh, diff;

  assign lastIter = rIsW ? (cnt == CNTW'(31)) : (cnt == CNTW'(XLEN - 1));

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  assign remSh = {remR, quo[XLEN-1]};
  assign diff  = remSh - {1'b0, divisor};

  // ---------------------------------------------------------------------------
  // Sign correction and half selection for the FIX cycle
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quoS, remS, divRes, fixRes;

  always_comb begin
    prod   = rNeg ? -acc : acc;
    quoS   = rNeg ? -quo : quo;
    remS   = rNegRem ? -remR : remR;
    divRes = rIsRem ? remS : quoS;
    if (rIsMul) begin
      if (rSelHi) begin
        fixRes = prod[PW-1:XLEN];
      end else if (rIsW) begin
        fixRes = sext32(prod[31:0]);
      end else begin
        fixRes = prod[XLEN-1:0];
      end
    end else begin
      fixRes = rIsW ? sext32(divRes[31:0]) : divRes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      rIsW      <= 1'b0;
      rIsMul    <= 1'b0;
      rIsRem    <= 1'b0;
      rSelHi    <= 1'b0;
      rNeg      <= 1'b0;
      rNegRem   <= 1'b0;
      rSpecial  <= 1'b0;
      rSpecRes  <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      remR      <= '0;
      quo       <= '0;
      divisor   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rIsW     <= dIsW;
            rIsMul   <= dIsMul;
            rIsRem   <= dIsRem;
            rSelHi   <= dSelHi;
            rNeg     <= negA ^ negB;
            rNegRem  <= negA;
            rSpecial <= special;
            rSpecRes <= specResC;
            acc      <= '0;
            mcand    <= PW'(magA);
            mplier   <= magB;
            remR     <= '0;
            // W dividends are left-aligned so the first 32 steps consume them.
            quo      <= dIsW ? (magA << (XLEN - 32)) : magA;
            divisor  <= magB;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (!dLegal) begin
              result    <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end
`ifdef MDU_EARLY_OUT_EN
            else if (special) begin
              result    <= specResC;
              state     <= DONE;
              out_valid <= 1'b1;
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (rIsMul) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else if (!diff[XLEN]) begin
            remR <= diff[XLEN-1:0];
            quo  <= {quo[XLEN-2:0], 1'b1};
          end else begin
            remR <= remSh[XLEN-1:0];
            quo  <= {quo[XLEN-2:0], 1'b0};
          end
          if (lastIter) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FIX: begin
          result    <= rSpecial ? rSpecRes : fixRes;
          state     <= DONE;
          out_valid <= 1'b1;
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- self-checking bench for mul_div_unit (XLEN = 64).
// Results are compared against an arithmetic reference model; latency is
// counted in rising edges from the accept edge (accept edge = 1).

module tb_mul_div_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [3:0]  op        = '0;
  logic [63:0] src1      = '0;
  logic [63:0] src2      = '0;
  logic        flush     = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  a32, b32;
    logic [31:0]         ua32, ub32, t;
    sa = a; sb = b;
    a32 = a[31:0]; b32 = b[31:0];
    ua32 = a[31:0]; ub32 = b[31:0];
    pa = sa; pb = sb;
    case (o)
      4'd0: return a * b;
      4'd1: begin p = pa * pb; return p[127:64]; end
      4'd2: begin pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'd3: begin pa = {64'd0, a}; pb = {64'd0, b}; p = pa * pb; return p[127:64]; end
      4'd4: begin
        if (b == '0) return '1;
        else if (a == MIN64 && b == '1) return MIN64;
        else return sa / sb;
      end
      4'd5: begin
        if (b == '0) return '1;
        else return a / b;
      end
      4'd6: begin
        if (b == '0) return a;
        else if (a == MIN64 && b == '1) return '0;
        else return sa % sb;
      end
      4'd7: begin
        if (b == '0) return a;
        else return a % b;
      end
      4'd8: begin t = ua32 * ub32; return sx(t); end
      4'd9: begin
        if (ub32 == '0) return '1;
        else if (ua32 == 32'h8000_0000 && ub32 == '1) return sx(32'h8000_0000);
        else return sx(a32 / b32);
      end
      4'd10: begin
        if (ub32 == '0) return '1;
        else return sx(ua32 / ub32);
      end
      4'd11: begin
        if (ub32 == '0) return sx(ua32);
        else if (ua32 == 32'h8000_0000 && ub32 == '1) return '0;
        else return sx(a32 % b32);
      end
      4'd12: begin
        if (ub32 == '0) return sx(ua32);
        else return sx(ua32 % ub32);
      end
      default: return '0;
    endcase
  endfunction

  function automatic int expLat(input logic [3:0] o, input logic [63:0] a,
                                input logic [63:0] b);
    logic sp;
    if (o > 4'd12) return 1;
    case (o)
      4'd4, 4'd6:   sp = (b == '0) || (a == MIN64 && b == '1);
      4'd5, 4'd7:   sp = (b == '0);
      4'd9, 4'd11:  sp = (b[31:0] == '0) || (a[31:0] == 32'h8000_0000 && b[31:0] == '1);
      4'd10, 4'd12: sp = (b[31:0] == '0);
      default:      sp = 1'b0;
    endcase
    if (sp && EARLY) return 1;
    return (o >= 4'd8) ? 34 : 66;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: issue one op from a negedge with in_ready high, wait (bounded)
  // for out_valid, capture result, pop it. Ends on a negedge in IDLE.
  // ---------------------------------------------------------------------------
  task automatic runOp(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops[7];
    logic [63:0] as[7], bs[7], exps[7];
    int          lats[7];
    logic [63:0] res;
    int          lat;
    ops  = '{4'd0, 4'd9, 4'd11, 4'd5, 4'd6, 4'd3, 4'd6};
    as   = '{64'd7, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'd5,
             64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
    bs   = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    exps = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_8000_0000, 64'd0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9,
             64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
    lats = '{66, EARLY ? 1 : 34, EARLY ? 1 : 34, EARLY ? 1 : 66, EARLY ? 1 : 66, 66, 66};
    for (int i = 0; i < 7; i++) begin
      runOp(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exps[i]) begin
        errors++;
        $display("FAIL directed_result[%0d] op=%0d got=%h exp=%h", i, ops[i], res, exps[i]);
      end
      checks++;
      if (lat != lats[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d] op=%0d got=%0d exp=%0d", i, ops[i], lat, lats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [63:0] a, b, res, expv;
    int          lat, el;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = {$urandom, 32'h0};
        1: begin a = MIN64; b = '1; end
        2: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
        3: begin
          a = 64'($urandom_range(0, 100));
          b = 64'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) a = -a;
        end
        4: b = '0;
        default: ;
      endcase
      expv = model(o, a, b);
      el   = expLat(o, a, b);
      runOp(o, a, b, res, lat);
      checks++;
      if (res !== expv) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, expv);
      end
      checks++;
      if (lat != el) begin
        errors++;
        $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", i, o, lat, el);
      end
    end
  endtask

  task automatic test_flush();
    int  n;
    bit  seen;
    // Flush mid-CALC: asserted for edge 10 after the accept edge.
    op = 4'd4; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_busy_in_ready got=%b exp=0", in_ready); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_calc_in_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_calc_no_out_valid got=1 exp=0"); end

    // Flush together with a request: must not accept (illegal op would finish in 1 edge).
    op = 4'd15; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_blocks_accept got=out_valid:%b,in_ready:%b exp=0,1", out_valid, in_ready);
    end

    // Flush in DONE drops the result.
    op = 4'd0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL flush_done_wait got=timeout exp=out_valid"); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_drop got=out_valid:%b,in_ready:%b exp=0,1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold();
    logic [63:0] a, b, expv;
    int          n;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    expv = model(4'd1, a, b);
    op = 4'd1; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 4'd15;  // keep a request pending throughout DONE
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n != 66) begin errors++; $display("FAIL hold_latency got=%0d exp=66", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result !== expv || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d] got=%h/%b/%b exp=%h/1/0", i, result, out_valid, in_ready, expv);
      end
      @(negedge clk);
    end
    // Pop with in_valid still high: no accept on the DONE->IDLE edge.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_pop got=in_ready:%b,out_valid:%b exp=1,0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    bit seen;
    int n;
    // Reset mid-CALC, between clock edges.
    op = 4'd4; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_calc got=%b/%b/%h exp=0/1/0", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL async_reset_calc_no_out got=1 exp=0"); end

    // Reset in DONE.
    op = 4'd8; src1 = 64'd6; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (result !== 64'd42) begin errors++; $display("FAIL async_done_result got=%h exp=2a", result); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_done got=%b/%b/%h exp=0/1/0", out_valid, in_ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL async_reset_done_no_out got=1 exp=0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
